instr_issue: RTL

Instruction issue stage that sits directly upstream of the four-stage `pipeline` datapath and drives its `rs1`, `rs2`, `rd`, `func` and `addr` inputs. It accepts packed 24-bit instruction words over a valid/ready handshake and buffers them in a small FIFO. It decodes each word into register/function/address fields and issues at most one instruction per cycle. With hazard checking compiled in, it inserts bubbles when a source register matches the destination of an instruction still in flight.

---
 rtl/instr_issue.sv | 133 +++++++++++++
 1 files changed

// File: rtl/instr_issue.sv
// Instruction issue stage: buffers 24-bit instruction words in a FIFO and issues one per cycle.
// Optional RAW hazard bubbles are enabled with the INSTR_ISSUE_HAZARD_EN macro.
module instr_issue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned HAZ_DEPTH = 2
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [23:0] in_word,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  rd,
  output logic [3:0]  func,
  output logic [7:0]  addr,
  output logic [15:0] issued_cnt,
  output logic [15:0] stall_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [23:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [23:0]     head;
  logic            push;
  logic            adv;
  logic            empty;
  logic            hazard;
  logic            issue;

  assign head     = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign in_ready = (count_q < FullCnt);
  assign push     = in_valid && in_ready;
  assign adv      = !out_valid || out_ready;
  assign issue    = adv && !empty && !hazard;

  // Storage needs no reset: only entries below count_q are ever read.
  always_ff @(posedge clk1) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_word;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_valid  <= 1'b0;
      rs1        <= '0;
      rs2        <= '0;
      rd         <= '0;
      func       <= '0;
      addr       <= '0;
      issued_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (issue) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, issue})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (adv) begin
        out_valid <= issue;
        if (issue) begin
          func <= head[23:20];
          rd   <= head[19:16];
          rs1  <= head[15:12];
          rs2  <= head[11:8];
          addr <= head[7:0];
          if (issued_cnt != 16'hFFFF) begin
            issued_cnt <= issued_cnt + 16'd1;
          end
        end
      end
    end
  end

`ifdef INSTR_ISSUE_HAZARD_EN
  logic [HAZ_DEPTH-1:0] hist_vld_q;
  logic [3:0]           hist_rd_q [HAZ_DEPTH];
  logic                 stall;

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < HAZ_DEPTH; i++) begin
      if (hist_vld_q[i] && (hist_rd_q[i] == head[15:12] || hist_rd_q[i] == head[11:8])) begin
        hazard = 1'b1;
      end
    end
  end

  assign stall = adv && !empty && hazard;

  // Entry 0 is the most recent issue slot; bubbles push an invalid entry.
  always_ff @(posedge clk1) begin
    if (rst) begin
      hist_vld_q <= '0;
      for (int unsigned i = 0; i < HAZ_DEPTH; i++) begin
        hist_rd_q[i] <= '0;
      end
      stall_cnt <= '0;
    end else if (adv) begin
      hist_vld_q[0] <= issue;
      hist_rd_q[0]  <= head[19:16];
      for (int unsigned i = 1; i < HAZ_DEPTH; i++) begin
        hist_vld_q[i] <= hist_vld_q[i-1];
        hist_rd_q[i]  <= hist_rd_q[i-1];
      end
      if (stall && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`else
  assign hazard    = 1'b0;
  assign stall_cnt = '0;
`endif

endmodule
